// File: rtl/division_secuencial.sv
`timescale 1ns/1ps
// Sequential restoring unsigned divider: quotient = a / b, remainder = a % b, one quotient bit per clock.
// Latency: start accepted at edge t -> done pulses in the cycle after edge t+m (throughput one per m+1 cycles).
// Backpressure: start is ignored while busy; a start held in the DONE cycle is accepted back-to-back.
// Optional build macro DIVISION_EARLY_ZERO_EN: b == 0 completes after a single cycle instead of m.
module division_secuencial #(
    parameter int m = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [m-1:0] quotient,
    output logic [m-1:0] remainder,
    output logic         div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW       = (m > 2) ? $clog2(m) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(m - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [m-1:0]  b_q;        // latched divisor
    logic [m-1:0]  q_q;        // dividend shifting out / quotient shifting in
    logic [m-1:0]  r_q;        // partial remainder (always < divisor between steps)
    logic          busy_q;
    logic          done_q;
    logic [m-1:0]  quotient_q;
    logic [m-1:0]  remainder_q;
    logic          div_zero_q;
`ifdef DIVISION_EARLY_ZERO_EN
    logic          zflag_q;    // current operation is a divide by zero taking the short path
`endif

    // Restoring step datapath; the shifted remainder needs m+1 bits before the trial subtract
    logic [m:0]    r_shift;
    logic          trial_ge;
    logic [m-1:0]  r_nxt;
    logic [m-1:0]  q_nxt;

    // One restoring step: shift {R,Q}, subtract B when it fits, record the quotient bit
    always_comb begin
        r_shift  = {r_q, q_q[m-1]};
        trial_ge = (r_shift >= {1'b0, b_q});
        // When the trial fits, the difference is below the divisor so the low m bits are exact
        r_nxt    = trial_ge ? (r_shift[m-1:0] - b_q) : r_shift[m-1:0];
        q_nxt    = {q_q[m-2:0], trial_ge};
    end

    // Control FSM plus all datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            b_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
`ifdef DIVISION_EARLY_ZERO_EN
            zflag_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE accepts a new start exactly like IDLE so divisions can run back-to-back
                IDLE, DONE: begin
                    if (start) begin
                        b_q     <= b;
                        q_q     <= a;
                        r_q     <= '0;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef DIVISION_EARLY_ZERO_EN
                        // A zero divisor only needs one RUN cycle to publish its fixed result
                        zflag_q <= (b == '0);
                        if (b == '0) begin
                            cnt_q <= '0;
                        end
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                RUN: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    if (cnt_q == '0) begin
                        quotient_q  <= q_nxt;
                        remainder_q <= r_nxt;
                        div_zero_q  <= (b_q == '0);
`ifdef DIVISION_EARLY_ZERO_EN
                        // q_q still holds the untouched dividend on the first RUN cycle
                        if (zflag_q) begin
                            quotient_q  <= '1;
                            remainder_q <= q_q;
                        end
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_division_secuencial.sv
`timescale 1ns/1ps
// Bench for division_secuencial (m=4): vector table, exhaustive back-to-back sweep and corner sequences.
// Expected results are queued when a start is accepted and compared when done pulses.
// Latency is checked per result against the start cycle recorded in the queue entry.
module tb_division_secuencial;

    localparam int M = 4;
`ifdef DIVISION_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [M-1:0] a     = '0;
    logic [M-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [M-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_zero;

    division_secuencial #(.m(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [M-1:0] q;
        logic [M-1:0] r;
        logic         dz;
        int           lat;
        int           sc;
    } exp_t;

    typedef struct {
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] q;
        logic [M-1:0] r;
        logic         dz;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    int cyc      = 0;
    int n_total  = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input logic [M-1:0] bv);
        return (EARLY && bv == '0) ? 1 : M;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_zero", div_zero, e.dz);
                check("latency", cyc - e.sc, e.lat);
            end
        end
    end

    // Called just after a rising edge; leaves time just after the accepting edge
    task automatic issue(input logic [M-1:0] av, input logic [M-1:0] bv,
                         input logic [M-1:0] eq, input logic [M-1:0] er,
                         input logic edz, input bit push);
        exp_t e;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.dz  = edz;
            e.lat = lat_of(bv);
            e.sc  = cyc;
            sb.push_back(e);
        end
        check("busy_after_start", busy, 1);
    endtask

    // Bounded wait for all queued results, then one edge so the FSM returns to IDLE
    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("results_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_quotient"}, quotient, 0);
        check({tag, "_remainder"}, remainder, 0);
        check({tag, "_div_zero"}, div_zero, 0);
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int d0;
        logic [M-1:0] av, bv, eq, er;

        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0};
        vecs[1] = '{4'd7,  4'd0,  4'd15, 4'd7,  1'b1};
        vecs[2] = '{4'd12, 4'd5,  4'd2,  4'd2,  1'b0};
        vecs[3] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
        vecs[4] = '{4'd0,  4'd7,  4'd0,  4'd0,  1'b0};
        vecs[5] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
        vecs[6] = '{4'd1,  4'd15, 4'd0,  4'd1,  1'b0};
        vecs[7] = '{4'd0,  4'd0,  4'd15, 4'd0,  1'b1};
        vecs[8] = '{4'd14, 4'd3,  4'd4,  4'd2,  1'b0};
        vecs[9] = '{4'd10, 4'd4,  4'd2,  4'd2,  1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table of single divisions, each run to completion
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b1);
            wait_idle();
        end

        // Exhaustive sweep with starts held into the DONE cycle
        for (int i = 0; i < 256; i++) begin
            av = 4'(i >> 4);
            bv = 4'(i);
            eq = (bv == '0) ? 4'hF : av / bv;
            er = (bv == '0) ? av : av % bv;
            issue(av, bv, eq, er, (bv == '0), 1'b1);
            repeat (lat_of(bv)) @(posedge clk);
            #1;
        end
        wait_idle();

        // Start while busy is ignored
        d0 = done_cnt;
        issue(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        a     = 4'd15;
        b     = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (8) @(posedge clk);
        #1;
        check("busy_start_done_count", done_cnt - d0, 1);

        // Reset in the middle of a division
        d0 = done_cnt;
        issue(4'd14, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrun_no_done", done_cnt - d0, 0);
        issue(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b1);
        wait_idle();

        // Results held while idle
        issue(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b1);
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_quotient", quotient, 2);
            check("hold_remainder", remainder, 2);
            check("hold_done", done, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
